// File: rtl/mul_norm_lzc_pipe.sv
// Two-stage normalisation control: S1 counts leading zeros of the raw product,
// S2 clamps the shift against the denormal floor and forms the adjusted exponent.
module mul_norm_lzc_pipe #(
  parameter  int WIDTH  = 48,
  parameter  int EWIDTH = 10,
  localparam int AWIDTH = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [EWIDTH-1:0] in_exp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [AWIDTH-1:0] out_shift,
  output logic [EWIDTH-1:0] out_exp,
  output logic              out_zero
);

  localparam int LWIDTH = AWIDTH + 1;
  localparam int CWIDTH = (EWIDTH > LWIDTH) ? EWIDTH : LWIDTH;

  logic              s1_valid_q;
  logic [WIDTH-1:0]  s1_data_q;
  logic [EWIDTH-1:0] s1_exp_q;
  logic [LWIDTH-1:0] s1_lzc_q;
  logic [LWIDTH-1:0] lzc_d;

  logic              s2_valid_q;
  logic [WIDTH-1:0]  s2_data_q;
  logic [AWIDTH-1:0] s2_shift_q;
  logic [EWIDTH-1:0] s2_exp_q;
  logic              s2_zero_q;
  logic [AWIDTH-1:0] shift_d;
  logic [EWIDTH-1:0] exp_d;
  logic              zero_d;

  logic s1_adv;
  logic s2_adv;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_shift = s2_shift_q;
  assign out_exp   = s2_exp_q;
  assign out_zero  = s2_zero_q;

  // Ascending scan: the highest set bit is the last to write, so it wins.
  always_comb begin
    lzc_d = LWIDTH'(WIDTH);
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (in_data[i]) lzc_d = LWIDTH'(WIDTH - 1 - i);
    end
  end

  always_comb begin
    zero_d  = (s1_lzc_q == LWIDTH'(WIDTH));
    shift_d = '0;
    exp_d   = '0;
    if (!zero_d) begin
      if (CWIDTH'(s1_lzc_q) < CWIDTH'(s1_exp_q)) begin
        shift_d = AWIDTH'(s1_lzc_q);
        exp_d   = s1_exp_q - EWIDTH'(s1_lzc_q);
      end else if (s1_exp_q != '0) begin
        // Here exp <= lzc <= WIDTH-1, so exp-1 always fits the shift field.
        shift_d = AWIDTH'(s1_exp_q - EWIDTH'(1));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_exp_q   <= '0;
      s1_lzc_q   <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_data_q <= in_data;
        s1_exp_q  <= in_exp;
        s1_lzc_q  <= lzc_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_shift_q <= '0;
      s2_exp_q   <= '0;
      s2_zero_q  <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_data_q  <= s1_data_q;
        s2_shift_q <= shift_d;
        s2_exp_q   <= exp_d;
        s2_zero_q  <= zero_d;
      end
    end
  end

endmodule
